// File: rtl/dm_arbiter.sv
// dm_arbiter
// Shares the single-port data memory between the CPU data port (requester 0)
// and a DMA/debug loader (requester 1). Grants are combinational, so a
// granted access completes in the same cycle it is requested.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   m0_req/we/addr/wdata/dmtype  CPU access request
//   m0_gnt, m0_stall, m0_rdata   CPU grant, PC freeze, read data (0 if not granted)
//   m1_req/we/addr/wdata/dmtype  requester 1 access request
//   m1_lock                    requester 1 asks to keep ownership next cycle
//   m1_gnt, m1_rdata           requester 1 grant and read data (0 if not granted)
//   dm_we/addr/din/dmtype      muxed memory controls (0 when nothing granted)
//   dm_dout                    combinational read data from the memory
module dm_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_dmtype,
    output logic        m0_gnt,
    output logic        m0_stall,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_dmtype,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic [2:0]  dm_dmtype,
    input  logic [31:0] dm_dout
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
    localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic [3:0] lock_cnt_reg, lock_cnt_next;
    logic       yield_reg, yield_next;
    logic       gnt0_arb, gnt1_arb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
            lock_cnt_reg <= 4'd0;
            yield_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            lock_cnt_reg <= lock_cnt_next;
            yield_reg    <= yield_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        lock_cnt_next = lock_cnt_reg;
        yield_next    = yield_reg;
        gnt0_arb      = 1'b0;
        gnt1_arb      = 1'b0;

        case (state_reg)
            IDLE: begin
                // yield only lives for the first IDLE cycle after a forced release
                yield_next = 1'b0;
                if (m0_req && m1_req) begin
                    if (yield_reg)
                        gnt0_arb = 1'b1;
                    else if (wait_cnt_reg == WAIT_MAX)
                        gnt1_arb = 1'b1;
                    else
                        gnt0_arb = 1'b1;
                end else if (m0_req) begin
                    gnt0_arb = 1'b1;
                end else if (m1_req) begin
                    gnt1_arb = 1'b1;
                end

                // The IDLE grant is the first beat of a locked burst. With a
                // one-beat limit the burst is already complete here.
                if (gnt1_arb && m1_lock) begin
                    if (LOCK_MAX == 4'd1) begin
                        yield_next = 1'b1;
                    end else begin
                        state_next    = LOCK1;
                        lock_cnt_next = 4'd1;
                    end
                end
            end

            LOCK1: begin
                // Requester 0 is shut out for the whole locked window.
                if (m1_req) begin
                    gnt1_arb = 1'b1;
                    if (!m1_lock) begin
                        state_next    = IDLE;
                        lock_cnt_next = 4'd0;
                    end else if (lock_cnt_reg + 4'd1 == LOCK_MAX) begin
                        state_next    = IDLE;
                        lock_cnt_next = 4'd0;
                        yield_next    = 1'b1;
                    end else begin
                        lock_cnt_next = lock_cnt_reg + 4'd1;
                    end
                end else begin
                    state_next    = IDLE;
                    lock_cnt_next = 4'd0;
                end
            end

            default: begin
                state_next    = IDLE;
                lock_cnt_next = 4'd0;
            end
        endcase

        if (gnt1_arb)
            wait_cnt_next = 4'd0;
        else if (m1_req && (wait_cnt_reg != WAIT_MAX))
            wait_cnt_next = wait_cnt_reg + 4'd1;
    end

    // Grants are masked by reset directly so ownership drops without a clock.
    assign m0_gnt   = gnt0_arb & rstn;
    assign m1_gnt   = gnt1_arb & rstn;
    assign m0_stall = m0_req & ~m0_gnt;

    assign dm_we     = (m0_gnt & m0_we) | (m1_gnt & m1_we);
    assign dm_addr   = m0_gnt ? m0_addr   : (m1_gnt ? m1_addr   : 32'd0);
    assign dm_din    = m0_gnt ? m0_wdata  : (m1_gnt ? m1_wdata  : 32'd0);
    assign dm_dmtype = m0_gnt ? m0_dmtype : (m1_gnt ? m1_dmtype : 3'd0);

    assign m0_rdata = m0_gnt ? dm_dout : 32'd0;
    assign m1_rdata = m1_gnt ? dm_dout : 32'd0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: each stimulus cycle pushes its expected
// outputs; a negedge monitor pops and compares one entry per cycle.
module tb_dm_arbiter;

    localparam logic [31:0] RD0 = 32'h1000_0004;  // background word at 0x10
    localparam logic [31:0] RD1 = 32'h1000_0008;  // background word at 0x20

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic [2:0]  m0_dmtype;
    logic        m0_gnt, m0_stall;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [2:0]  m1_dmtype;
    logic        m1_gnt;
    logic [31:0] m1_rdata;
    logic        dm_we;
    logic [31:0] dm_addr, dm_din, dm_dout;
    logic [2:0]  dm_dmtype;

    always #5 clk = ~clk;

    dm_arbiter #(.MAX_WAIT(4), .MAX_LOCK(8)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_dmtype(m0_dmtype), .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_dmtype(m1_dmtype), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dmtype(dm_dmtype),
        .dm_dout(dm_dout)
    );

    // Memory model: combinational read, write on rising edge. Unwritten
    // words read back as 0x1000_0000 + word index.
    logic [31:0] mem [0:255];
    bit          wr_valid [0:255];
    assign dm_dout = wr_valid[dm_addr[9:2]] ? mem[dm_addr[9:2]]
                                            : (32'h1000_0000 | {24'd0, dm_addr[9:2]});
    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr[9:2]]      <= dm_din;
            wr_valid[dm_addr[9:2]] <= 1'b1;
        end
    end

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        stall;
        logic        we;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] addr;
        logic [31:0] din;
        logic [2:0]  dmt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    // Monitor: one comparison per stimulus cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{m0_gnt, m1_gnt, m0_stall, dm_we, m0_rdata, m1_rdata, dm_addr, dm_din, dm_dmtype};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got g0=%b g1=%b stall=%b we=%b rd0=%h rd1=%h addr=%h din=%h dmt=%h, want g0=%b g1=%b stall=%b we=%b rd0=%h rd1=%h addr=%h din=%h dmt=%h",
                         t, a.g0, a.g1, a.stall, a.we, a.rd0, a.rd1, a.addr, a.din, a.dmt,
                         e.g0, e.g1, e.stall, e.we, e.rd0, e.rd1, e.addr, e.din, e.dmt);
            end else begin
                $display("ok %s: g0=%b g1=%b stall=%b we=%b rd0=%h rd1=%h addr=%h",
                         t, a.g0, a.g1, a.stall, a.we, a.rd0, a.rd1, a.addr);
            end
        end
    end

    // One cycle: apply requests, push the hand-computed expectation (grants
    // e0/e1 and the read word erd), optionally pull reset mid-cycle.
    task automatic step(input logic r0, input logic r1, input logic lk,
                        input logic e0, input logic e1, input logic [31:0] erd,
                        input string tag, input logic mid_rst = 1'b0);
        exp_t e;
        m0_req  = r0;
        m1_req  = r1;
        m1_lock = lk;
        e.g0    = e0;
        e.g1    = e1;
        e.stall = r0 & ~e0;
        e.we    = (e0 & m0_we) | (e1 & m1_we);
        e.rd0   = e0 ? erd : 32'd0;
        e.rd1   = e1 ? erd : 32'd0;
        e.addr  = e0 ? m0_addr   : (e1 ? m1_addr   : 32'd0);
        e.din   = e0 ? m0_wdata  : (e1 ? m1_wdata  : 32'd0);
        e.dmt   = e0 ? m0_dmtype : (e1 ? m1_dmtype : 3'd0);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (mid_rst) begin
            #2 rstn = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = 32'd0; m0_dmtype = 3'd2;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h20; m1_wdata = 32'd0; m1_dmtype = 3'd5;
        m1_lock = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds both grants low even with both requesting.
        step(1, 1, 0, 0, 0, 32'd0, "reset_hold");
        rstn = 1'b1;
        step(1, 1, 0, 1, 0, RD0, "reset_first_conflict");

        // Solo accesses through address 0x40.
        m0_addr = 32'h40; m0_we = 1'b1; m0_wdata = 32'hDEAD_BEEF;
        step(1, 0, 0, 1, 0, 32'h1000_0010, "m0_store");
        m0_we = 1'b0; m0_wdata = 32'd0;
        step(1, 0, 0, 1, 0, 32'hDEAD_BEEF, "m0_load");
        step(0, 0, 0, 0, 0, 32'd0, "idle");
        m1_addr = 32'h40;
        step(0, 1, 0, 0, 1, 32'hDEAD_BEEF, "m1_load");
        m0_addr = 32'h10; m1_addr = 32'h20;

        // Continuous conflict: 0,0,0,0,1 repeating.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, RD0, "conflict_m0");
            step(1, 1, 0, 0, 1, RD1, "conflict_m1");
        end

        // Locked burst of 12 beats against a continuous CPU.
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, RD0, "lock_wait_m0");
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 1, RD1, "lock_beat");
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, RD0, "lock_yield_m0");
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 1, RD1, "lock_resume");
        step(1, 0, 1, 0, 0, 32'd0, "lock_m0_blocked");
        step(1, 0, 0, 1, 0, RD0, "lock_after_m0");

        // Lock released early on beat 3.
        step(0, 1, 1, 0, 1, RD1, "early_b1");
        step(1, 1, 1, 0, 1, RD1, "early_b2");
        step(1, 1, 0, 0, 1, RD1, "early_b3_unlock");
        step(1, 1, 0, 1, 0, RD0, "early_m0_next");

        // Asynchronous reset during beat 5 of a locked write burst.
        m1_we = 1'b1; m1_wdata = 32'hA5A5_0000;
        step(0, 1, 1, 0, 1, RD1, "rst_burst_b1");
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 1, 32'hA5A5_0000, "rst_burst_beat");
        step(1, 1, 1, 0, 0, 32'd0, "rst_mid_beat5", 1'b1);
        rstn = 1'b1; m1_we = 1'b0; m1_wdata = 32'd0;
        step(1, 1, 1, 1, 0, RD0, "rst_back_idle");
        step(0, 0, 0, 0, 0, 32'd0, "tail_idle");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
